// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART constants, receiver FSM encoding and divider helper
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int OVS       = 16;
    localparam int DATA_BITS = 8;

    localparam logic [3:0] SAMPLE_MID  = 4'd9;
    localparam logic [3:0] SAMPLE_LAST = 4'd15;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    // clk cycles per oversample tick, truncated; shared with the transmitter baud generator
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVS);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_tick.sv
// ============================================================================
// uart_rx_tick : oversample tick divider, counts 0..DIV-1 with synchronous clear
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module uart_rx_tick #(
    parameter int DIV = 325
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == C_LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_frame.sv
// ============================================================================
// uart_rx_frame : 8N1 UART receiver, 16x oversampling, majority vote of 7/8/9
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_int,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam logic [2:0] C_LAST_BIT = 3'(DATA_BITS - 1);

    logic [2:0] sync_q, sync_d;
    logic [2:0] state_q, state_d;
    logic [3:0] samp_cnt_q, samp_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       s7_q, s7_d;
    logic       s8_q, s8_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_int_q, rx_int_d;
    logic       rx_busy_q, rx_busy_d;
    logic       frame_err_q, frame_err_d;

    logic       tick;
    logic       div_clr;
    logic       line;
    logic       fall;
    logic       maj;

    uart_rx_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (div_clr),
        .tick  (tick)
    );

    // sync_q[1] is the synchronized line, sync_q[2] its one-cycle history
    assign line = sync_q[1];
    assign fall = sync_q[2] & ~sync_q[1];
    assign maj  = (s7_q & s8_q) | (s7_q & line) | (s8_q & line);

    always_comb begin
        sync_d      = {sync_q[1:0], rs232_rx};
        state_d     = state_q;
        samp_cnt_d  = samp_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        s7_d        = s7_q;
        s8_d        = s8_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_int_d    = 1'b1;
        rx_busy_d   = rx_busy_q;
        frame_err_d = 1'b0;
        div_clr     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d    = ST_START;
                    div_clr    = 1'b1;
                    samp_cnt_d = 4'd0;
                end
            end
            ST_START, ST_DATA, ST_STOP: begin
                if (tick) begin
                    samp_cnt_d = samp_cnt_q + 4'd1;
                    if (samp_cnt_q == SAMPLE_MID - 4'd2) s7_d = line;
                    if (samp_cnt_q == SAMPLE_MID - 4'd1) s8_d = line;

                    if (state_q == ST_START) begin
                        if (samp_cnt_q == SAMPLE_MID) begin
                            if (maj) begin
                                state_d    = ST_IDLE;
                                samp_cnt_d = 4'd0;
                            end else begin
                                rx_busy_d = 1'b1;
                            end
                        end
                        if (samp_cnt_q == SAMPLE_LAST) begin
                            state_d   = ST_DATA;
                            bit_idx_d = 3'd0;
                        end
                    end else if (state_q == ST_DATA) begin
                        if (samp_cnt_q == SAMPLE_MID) begin
                            shift_d[bit_idx_q] = maj;
                        end
                        if (samp_cnt_q == SAMPLE_LAST) begin
                            if (bit_idx_q == C_LAST_BIT) begin
                                state_d = ST_STOP;
                            end else begin
                                bit_idx_d = bit_idx_q + 3'd1;
                            end
                        end
                    end else if (samp_cnt_q == SAMPLE_MID) begin
                        // Leave mid stop bit so a back-to-back start edge is not missed
                        samp_cnt_d = 4'd0;
                        bit_idx_d  = 3'd0;
                        if (maj) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            rx_int_d   = 1'b0;
                            rx_busy_d  = 1'b0;
                            state_d    = ST_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_BREAK;
                        end
                    end
                end
            end
            ST_BREAK: begin
                if (line) begin
                    rx_busy_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                rx_busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 3'b111;
            state_q     <= ST_IDLE;
            samp_cnt_q  <= 4'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            s7_q        <= 1'b0;
            s8_q        <= 1'b0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            rx_int_q    <= 1'b1;
            rx_busy_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            samp_cnt_q  <= samp_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            s7_q        <= s7_d;
            s8_q        <= s8_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_int_q    <= rx_int_d;
            rx_busy_q   <= rx_busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_int    = rx_int_q;
    assign rx_busy   = rx_busy_q;
    assign frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
// ============================================================================
// tb_uart_rx_frame : directed bench for uart_rx_frame at DIV=10 (160 clk/bit)
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_frame;

    logic       clk;
    logic       rst_n;
    logic       rs232_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_int;
    logic       rx_busy;
    logic       frame_err;

    int total = 0;
    int bad   = 0;

    // strobe monitor state
    int         cyc       = 0;
    int         n_valid   = 0;
    int         n_int     = 0;
    int         n_ferr    = 0;
    int         n_wide    = 0;
    int         n_misalign = 0;
    int         t_last    = 0;
    int         t_prev    = 0;
    logic [7:0] d_last    = 8'd0;
    logic [7:0] d_prev    = 8'd0;
    logic       valid_r   = 1'b0;
    logic       int_r     = 1'b1;

    uart_rx_frame #(
        .CLK_FREQ (1600000),
        .BAUD     (10000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs232_rx  (rs232_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_int    (rx_int),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (rx_valid) begin
                n_valid <= n_valid + 1;
                t_prev  <= t_last;
                t_last  <= cyc;
                d_prev  <= d_last;
                d_last  <= rx_data;
            end
            if (!rx_int) n_int <= n_int + 1;
            if (frame_err) n_ferr <= n_ferr + 1;
            if ((rx_valid && valid_r) || (!rx_int && !int_r)) n_wide <= n_wide + 1;
            if (rx_valid == rx_int) n_misalign <= n_misalign + 1;
            valid_r <= rx_valid;
            int_r   <= rx_int;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int per);
        rs232_rx = 1'b0;
        wait_clk(per);
        for (int i = 0; i < 8; i++) begin
            rs232_rx = d[i];
            wait_clk(per);
        end
        rs232_rx = stop;
        wait_clk(per);
    endtask

    int b_valid, b_int, b_ferr;

    initial begin
        rst_n    = 1'b0;
        rs232_rx = 1'b1;
        wait_clk(5);
        check("rst_data",  32'(rx_data), 32'h00);
        check("rst_valid", 32'(rx_valid), 32'h0);
        check("rst_int",   32'(rx_int), 32'h1);
        check("rst_busy",  32'(rx_busy), 32'h0);
        check("rst_ferr",  32'(frame_err), 32'h0);
        rst_n = 1'b1;
        wait_clk(40);

        // 0xA5, nominal rate
        b_valid = n_valid; b_int = n_int; b_ferr = n_ferr;
        send_frame(8'hA5, 1'b1, 160);
        wait_clk(20);
        check("a5_data",  32'(rx_data), 32'hA5);
        check("a5_nvalid", 32'(n_valid - b_valid), 32'd1);
        check("a5_nint",   32'(n_int - b_int), 32'd1);
        check("a5_ferr",   32'(n_ferr - b_ferr), 32'd0);
        check("a5_busy",   32'(rx_busy), 32'h0);

        // back-to-back 0x00 then 0xFF
        b_valid = n_valid;
        send_frame(8'h00, 1'b1, 160);
        send_frame(8'hFF, 1'b1, 160);
        wait_clk(20);
        check("b2b_nvalid", 32'(n_valid - b_valid), 32'd2);
        check("b2b_first",  32'(d_prev), 32'h00);
        check("b2b_second", 32'(rx_data), 32'hFF);
        check("b2b_gap",    32'((t_last - t_prev) >= 1590 && (t_last - t_prev) <= 1610), 32'd1);

        // 60-clk glitch on idle line
        b_valid = n_valid; b_int = n_int;
        rs232_rx = 1'b0;
        wait_clk(60);
        rs232_rx = 1'b1;
        wait_clk(200);
        check("glitch_busy",   32'(rx_busy), 32'h0);
        check("glitch_nvalid", 32'(n_valid - b_valid), 32'd0);
        check("glitch_nint",   32'(n_int - b_int), 32'd0);
        check("glitch_data",   32'(rx_data), 32'hFF);

        // framing error followed by a long break
        b_valid = n_valid; b_int = n_int; b_ferr = n_ferr;
        send_frame(8'h3C, 1'b0, 160);
        wait_clk(2000);
        check("brk_ferr",   32'(n_ferr - b_ferr), 32'd1);
        check("brk_nint",   32'(n_int - b_int), 32'd0);
        check("brk_nvalid", 32'(n_valid - b_valid), 32'd0);
        check("brk_busy",   32'(rx_busy), 32'h1);
        check("brk_data",   32'(rx_data), 32'hFF);
        rs232_rx = 1'b1;
        wait_clk(10);
        check("brk_busy_rel", 32'(rx_busy), 32'h0);
        wait_clk(200);

        // baud tolerance: -3% then +3%
        send_frame(8'h5A, 1'b1, 155);
        wait_clk(40);
        check("slow_fast_155", 32'(rx_data), 32'h5A);
        send_frame(8'h00, 1'b1, 160);
        wait_clk(40);
        check("tol_sep", 32'(rx_data), 32'h00);
        send_frame(8'h5A, 1'b1, 165);
        wait_clk(40);
        check("tol_165", 32'(rx_data), 32'h5A);

        // reset during data bit 4 of 0x81
        b_valid = n_valid;
        rs232_rx = 1'b0;
        wait_clk(160);
        for (int i = 0; i < 4; i++) begin
            rs232_rx = (i == 0) ? 1'b1 : 1'b0;
            wait_clk(160);
        end
        rs232_rx = 1'b0;
        wait_clk(80);
        check("abort_busy_pre", 32'(rx_busy), 32'h1);
        rst_n = 1'b0;
        wait_clk(5);
        check("abort_busy_rst", 32'(rx_busy), 32'h0);
        check("abort_data_rst", 32'(rx_data), 32'h00);
        rst_n = 1'b1;
        rs232_rx = 1'b1;
        wait_clk(400);
        check("abort_nvalid", 32'(n_valid - b_valid), 32'd0);
        send_frame(8'h81, 1'b1, 160);
        wait_clk(20);
        check("abort_resend_data",   32'(rx_data), 32'h81);
        check("abort_resend_nvalid", 32'(n_valid - b_valid), 32'd1);

        // strobe shape over the whole run
        check("strobe_width", 32'(n_wide), 32'd0);
        check("strobe_align", 32'(n_misalign), 32'd0);
        check("strobe_total", 32'(n_int), 32'(n_valid));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
